// File: rtl/ppu_pkg.sv
// ppu_pkg: shared constants and types for the PPU-to-VGA scanline path.
// Raster geometry, palette index type and read-side FSM encoding.
package ppu_pkg;

  localparam int LINE_W = 256;
  localparam int LINE_H = 240;
  localparam int H_LAST = 799;
  localparam int V_LAST = 524;

  typedef logic [5:0] pal_idx_t;

  localparam pal_idx_t BLANK_IDX = 6'h0F;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    STARVE
  } rd_state_t;

endpackage

// File: rtl/line_ram.sv
// line_ram: 512x6 simple dual-port RAM holding both scanline banks.
// Address is {bank, x}; the read port is synchronous.
module line_ram
  import ppu_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [8:0] waddr,
  input  pal_idx_t   wdata,
  input  logic       re,
  input  logic [8:0] raddr,
  output pal_idx_t   rdata
);

  pal_idx_t mem [512];
  pal_idx_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ppu_scanline_buffer.sv
// ppu_scanline_buffer: ping-pong line store between the PPU pixel stream
// and the VGA raster, with lookahead reads and sticky underrun.
module ppu_scanline_buffer #(
  parameter int                LINE_W    = ppu_pkg::LINE_W,
  parameter int                LINE_H    = ppu_pkg::LINE_H,
  parameter int                H_LAST    = ppu_pkg::H_LAST,
  parameter int                V_LAST    = ppu_pkg::V_LAST,
  parameter ppu_pkg::pal_idx_t BLANK_IDX = ppu_pkg::BLANK_IDX
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  ppu_pkg::pal_idx_t pix_idx,
  output logic              pix_ready,
  input  logic [9:0]        hc,
  input  logic [9:0]        vc,
  output ppu_pkg::pal_idx_t palette_disp_idx,
  output logic              underrun,
  output logic              rd_bank,
  output logic              wr_bank
);

  import ppu_pkg::*;

  localparam logic [9:0] HL     = 10'(H_LAST);
  localparam logic [9:0] VL     = 10'(V_LAST);
  localparam logic [9:0] LW     = 10'(LINE_W);
  localparam logic [9:0] LH     = 10'(LINE_H);
  localparam logic [7:0] X_LAST = 8'(LINE_W - 1);

  rd_state_t  state_q, state_d;
  logic       rd_bank_q, rd_bank_d;
  logic       wr_bank_q, wr_bank_d;
  logic [7:0] wr_x_q, wr_x_d;
  logic [1:0] full_q, full_d;
  logic       underrun_q, underrun_d;
  logic       show_q, show_d;

  logic [9:0] la_h, la_v;
  logic       line_start;
  logic       wr_en, rd_en;
  pal_idx_t   ram_rdata;

  // Lookahead: fetch the pixel for the next hc so the registered
  // output lines up with the raster; vc wraps into the next frame.
  always_comb begin
    la_h = hc + 10'd1;
    la_v = vc;
    if (hc == HL) begin
      la_h = '0;
      la_v = (vc == VL) ? '0 : vc + 10'd1;
    end
  end

  assign line_start = (hc == HL) && (la_v < LH);
  assign pix_ready  = !full_q[wr_bank_q];

  always_comb begin
    state_d    = state_q;
    rd_bank_d  = rd_bank_q;
    wr_bank_d  = wr_bank_q;
    wr_x_d     = wr_x_q;
    full_d     = full_q;
    underrun_d = underrun_q;
    rd_en      = 1'b0;
    wr_en      = pix_valid && pix_ready && !frame_start;

    if (wr_en) begin
      wr_x_d = wr_x_q + 8'd1;
      if (wr_x_q == X_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Bank release is applied after the writer's set so it wins.
    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          if (full_q[rd_bank_q]) begin
            state_d = READ;
            rd_en   = 1'b1;
          end else begin
            state_d    = STARVE;
            underrun_d = 1'b1;
          end
        end
      end
      READ: begin
        if (la_h < LW) begin
          rd_en = 1'b1;
        end else begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          state_d           = IDLE;
        end
      end
      STARVE: begin
        if (la_h == LW) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      state_d   = IDLE;
      rd_bank_d = 1'b0;
      wr_bank_d = 1'b0;
      wr_x_d    = '0;
      full_d    = '0;
      rd_en     = 1'b0;
    end

    show_d = rd_en;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_x_q     <= '0;
      full_q     <= '0;
      underrun_q <= 1'b0;
      show_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      wr_bank_q  <= wr_bank_d;
      wr_x_q     <= wr_x_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
      show_q     <= show_d;
    end
  end

  line_ram u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank_q, wr_x_q}),
    .wdata (pix_idx),
    .re    (rd_en),
    .raddr ({rd_bank_q, la_h[7:0]}),
    .rdata (ram_rdata)
  );

  assign palette_disp_idx = show_q ? ram_rdata : BLANK_IDX;
  assign underrun         = underrun_q;
  assign rd_bank          = rd_bank_q;
  assign wr_bank          = wr_bank_q;

endmodule

// File: tb/tb_ppu_scanline_buffer.sv
// tb_ppu_scanline_buffer: directed raster and pixel stimulus; expected
// values are queued per cycle and checked by a separate monitor.
module tb_ppu_scanline_buffer;

  import ppu_pkg::*;

  localparam int K_DISP = 0;
  localparam int K_RDY  = 1;
  localparam int K_UNR  = 2;
  localparam int K_RDB  = 3;
  localparam int K_WRB  = 4;

  typedef struct {
    int    cyc;
    int    kind;
    int    val;
    string name;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       frame_start;
  logic       pix_valid;
  pal_idx_t   pix_idx;
  logic       pix_ready;
  logic [9:0] hc;
  logic [9:0] vc;
  pal_idx_t   palette_disp_idx;
  logic       underrun;
  logic       rd_bank;
  logic       wr_bank;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  exp_t     sb[$];
  pal_idx_t pix_q[$];

  bit fs_arm   = 1'b0;
  int fs_after = 0;

  ppu_scanline_buffer dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .frame_start      (frame_start),
    .pix_valid        (pix_valid),
    .pix_idx          (pix_idx),
    .pix_ready        (pix_ready),
    .hc               (hc),
    .vc               (vc),
    .palette_disp_idx (palette_disp_idx),
    .underrun         (underrun),
    .rd_bank          (rd_bank),
    .wr_bank          (wr_bank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic pal_idx_t pat(input int x, input int seed);
    return pal_idx_t'((x + seed) & 63);
  endfunction

  task automatic want(input int kind, input int val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic queue_line(input int seed);
    for (int x = 0; x < 256; x++) pix_q.push_back(pat(x, seed));
  endtask

  // One raster cycle: retire last cycle's handshake, then drive new inputs.
  task automatic cyc_drive(input int h, input int v);
    bit acc;
    @(negedge clk);
    acc = pix_valid && pix_ready && reset_n;
    @(posedge clk);
    #1;
    if (acc) begin
      void'(pix_q.pop_front());
      n_acc++;
    end
    hc        = 10'(h);
    vc        = 10'(v);
    pix_valid = pix_q.size() > 0;
    pix_idx   = pix_valid ? pix_q[0] : '0;
    frame_start = fs_arm && pix_valid && (n_acc == fs_after);
    if (frame_start) fs_arm = 1'b0;
  endtask

  task automatic run_seg(input int v, input int h0, input int h1,
                         input bit show, input int seed);
    for (int h = h0; h <= h1; h++) begin
      cyc_drive(h, v);
      want(K_DISP, (show && h < 256) ? int'(pat(h, seed)) : 15, "disp");
    end
  endtask

  task automatic run_line(input int v, input bit show, input int seed,
                          input int last_h);
    run_seg(v, 0, last_h, show, seed);
    run_seg(v, 799, 799, show, seed);
  endtask

  task automatic want_reset_vals(input string tag);
    want(K_DISP, 15, {tag, "_disp"});
    want(K_RDY,  1,  {tag, "_ready"});
    want(K_UNR,  0,  {tag, "_underrun"});
    want(K_RDB,  0,  {tag, "_rd_bank"});
    want(K_WRB,  0,  {tag, "_wr_bank"});
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      int   got;
      e = sb.pop_front();
      case (e.kind)
        K_DISP:  got = int'(palette_disp_idx);
        K_RDY:   got = int'(pix_ready);
        K_UNR:   got = int'(underrun);
        K_RDB:   got = int'(rd_bank);
        K_WRB:   got = int'(wr_bank);
        default: got = -1;
      endcase
      n_chk++;
      if (got == e.val && e.cyc == cyc) n_pass++;
      else $display("FAIL %s cyc=%0d hc=%0d vc=%0d got=%0h want=%0h",
                    e.name, e.cyc, hc, vc, got, e.val);
    end
  end

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    pix_idx     = '0;
    hc          = '0;
    vc          = 10'd524;

    cyc_drive(0, 524);
    cyc_drive(0, 524);
    want_reset_vals("rst");
    reset_n = 1'b1;

    // Three banks' worth queued: two fill, the third waits on backpressure.
    queue_line(0);
    queue_line(21);
    queue_line(42);
    run_seg(524, 0, 0, 0, 0);
    want(K_RDY, 1, "pre_ready0");
    run_seg(524, 1, 256, 0, 0);
    want(K_WRB, 1, "pre_wrbank256");
    run_seg(524, 257, 511, 0, 0);
    want(K_RDY, 1, "pre_ready511");
    run_seg(524, 512, 512, 0, 0);
    want(K_RDY, 0, "pre_ready512");
    want(K_WRB, 0, "pre_wrbank512");
    run_seg(524, 513, 599, 0, 0);
    run_seg(524, 799, 799, 0, 0);

    run_seg(0, 0, 255, 1, 0);
    want(K_RDY, 0, "l0_ready255");
    run_seg(0, 256, 256, 1, 0);
    want(K_RDY, 1, "l0_ready256");
    want(K_RDB, 1, "l0_rdbank256");
    run_seg(0, 257, 512, 1, 0);
    want(K_RDY, 0, "l0_ready512");
    run_seg(0, 513, 798, 1, 0);
    run_seg(0, 799, 799, 1, 0);
    want(K_UNR, 0, "l0_underrun");

    run_line(1, 1, 21, 259);
    queue_line(13);
    run_line(2, 1, 42, 259);
    want(K_RDB, 1, "l2_rdbank");

    // Jump to the last visible lines, then through vertical blank.
    queue_line(15);
    run_line(239, 1, 13, 259);
    run_line(240, 0, 0, 259);
    want(K_UNR, 0, "l240_underrun");
    run_line(400, 0, 0, 259);
    run_line(524, 0, 0, 259);
    want(K_UNR, 0, "l524_underrun");
    run_line(0, 1, 15, 259);
    want(K_UNR, 0, "f2l0_underrun");

    queue_line(7);
    run_seg(1, 0, 0, 0, 0);
    want(K_UNR, 1, "starve_underrun");
    run_seg(1, 1, 259, 0, 0);
    run_seg(1, 799, 799, 0, 0);
    want(K_RDB, 1, "starve_rdbank");
    run_line(2, 1, 7, 259);

    for (int x = 0; x < 100; x++) pix_q.push_back(pat(x, 9));
    pix_q.push_back(6'h3F);
    queue_line(11);
    fs_arm   = 1'b1;
    fs_after = n_acc + 100;
    run_seg(3, 0, 100, 0, 0);
    run_seg(3, 101, 101, 0, 0);
    want(K_RDY, 1, "fs_ready");
    want(K_RDB, 0, "fs_rdbank");
    want(K_WRB, 0, "fs_wrbank");
    want(K_UNR, 1, "fs_underrun");
    run_seg(3, 102, 499, 0, 0);
    run_seg(3, 799, 799, 0, 0);

    run_seg(4, 0, 127, 1, 11);
    cyc_drive(128, 4);
    #2;
    reset_n = 1'b0;
    want_reset_vals("arst");
    cyc_drive(129, 4);
    want_reset_vals("arst_hold");
    reset_n = 1'b1;

    run_line(524, 0, 0, 259);
    want(K_UNR, 0, "r2_pre_underrun");
    queue_line(5);
    run_seg(0, 0, 0, 0, 0);
    want(K_UNR, 1, "r2_underrun");
    run_seg(0, 1, 259, 0, 0);
    run_seg(0, 799, 799, 0, 0);
    want(K_RDB, 0, "r2_rdbank");
    run_line(1, 1, 5, 259);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain pending=%0d", sb.size());
      n_chk += sb.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ppu_scanline_buffer.md
# ppu_scanline_buffer

- Ping-pong scanline buffer between the PPU pixel pipeline and the VGA controller.
- The PPU pushes 256 palette indices per line under a valid/ready handshake.
- The VGA side reads them back using the controller's `hc`/`vc` counters and returns a registered `palette_disp_idx` aligned to the current `hc`.
- Decouples PPU pixel timing from the 800x525 VGA raster; provides backpressure and underrun detection.

## Interface
Parameters:
- `LINE_W`, 256, visible pixels per NES line
- `LINE_H`, 240, visible NES lines
- `H_LAST`, 799, last VGA `hc` value
- `BLANK_IDX`, 6'h0F, palette index driven outside valid data

Ports:
- `clk` in 1: system clock, shared with the VGA controller
- `reset_n` in 1: asynchronous, active-low reset
- `frame_start` in 1: one-cycle pulse from the PPU at pre-render end; resynchronises the buffer
- `pix_valid` in 1: PPU pixel present
- `pix_idx` in 6: PPU palette index
- `pix_ready` out 1: buffer accepts a pixel this cycle
- `hc` in 10: VGA horizontal counter
- `vc` in 10: VGA vertical counter
- `palette_disp_idx` out 6: registered pixel for the current `hc`/`vc`
- `underrun` out 1: sticky; a visible VGA line found no full bank
- `rd_bank`, `wr_bank` out 1 each: debug, current bank selects

## Operation
Storage and flags:
- Two banks of `LINE_W` x 6 bits.
- One `full[1:0]` flag per bank.

Write side:
- Pointer `wr_x` (8 b); bank `wr_bank`.
- Transfer happens when `pix_valid && pix_ready`: write `pix_idx` to `[wr_bank][wr_x]`, then `wr_x++`.
- On the transfer with `wr_x==LINE_W-1`: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_x` to 0.
- `pix_ready = !full[wr_bank]`.

Read side uses lookahead coordinates:
- `la_h = (hc==H_LAST) ? 0 : hc+1`.
- `la_v = vc+1` when `hc==H_LAST`, else `vc`.
- Line start: when `hc==H_LAST` and `la_v < LINE_H`, the read FSM decides for the line.

Read FSM states:
- `IDLE`
  - At line start with `full[rd_bank]`: go to `READ`.
  - At line start without it: go to `STARVE` and set `underrun`.
- `READ`
  - Each cycle with `la_h < LINE_W`: `palette_disp_idx <= bank[rd_bank][la_h]`.
  - Once `la_h == LINE_W`: clear `full[rd_bank]`, toggle `rd_bank`, go to `IDLE`.
- `STARVE`
  - Output `BLANK_IDX` for the line.
  - Return to `IDLE` at `la_h == LINE_W`.
  - No bank released.

Output outside `READ` is `BLANK_IDX`.

`frame_start` forces, next edge:
- `wr_x=0`, `wr_bank=0`, `rd_bank=0`, `full=0`, FSM to `IDLE`.
- `underrun` is not cleared.

Simultaneous events:
- Writer sets and reader clears the same `full` bit in one cycle: cannot occur, because the banks differ by construction.
- If they coincide after a fault, the clear wins.
- `frame_start` together with a pixel transfer: `frame_start` wins and the pixel is dropped.

## Timing
- Reset values: `pix_ready=1`, `palette_disp_idx=BLANK_IDX`, `underrun=0`, `rd_bank=0`, `wr_bank=0`; all flags 0, FSM in `IDLE`.
- Reset is asynchronous assert and synchronous-safe deassert; reset mid-line discards all buffered data.
- Read latency:
  - One registered cycle; lookahead makes `palette_disp_idx` valid in the same cycle `hc` shows the matching pixel.
  - Pixel at `hc=0` is loaded on the `hc==H_LAST` edge of the previous line.
- Write:
  - Throughput one pixel/cycle.
  - Bank release is visible to the writer one cycle after the clearing edge, so `pix_ready` rises then.
- `underrun` is sticky until `reset_n`.

## Structure
Shared package `ppu_pkg` holds:
- `LINE_W`, `LINE_H`, `H_LAST`, `BLANK_IDX`
- `typedef logic [5:0] pal_idx_t`
- read-FSM enum `{IDLE, READ, STARVE}`

Sub-module `line_ram`:
- 512x6 simple dual-port RAM, one write port, one synchronous read port.
- Address is `{bank, x}`.

## Test plan
- **Basic line:** reset; push 256 pixels `x[5:0]` at full rate before VGA line 0 → `palette_disp_idx==hc[5:0]` for `hc` 0..255; `BLANK_IDX` at `hc` 256..799.
- **Backpressure:** push 512 pixels before line 0 → `pix_ready` drops after pixel 511; it rises one cycle after `la_h==256` of line 0; next line reads the second bank.
- **Underrun:** push nothing; line 0 starts → output `6'h0F` all line, `underrun=1`, `rd_bank` stays 0. Then fill a bank → line 1 displays the data.
- **Wrap:** stream 240 lines in lockstep → lines 240..524 output `BLANK_IDX`; `vc` wrap to 0 reads the next PPU frame, no underrun.
- **frame_start mid-line:** after 100 pixels, pulse `frame_start` with `pix_valid` high → that pixel is dropped, `wr_x=0`, `full=0`; the next 256 pixels land at `x=0..255`.
- **Async reset during READ:** at `hc=128`, assert `reset_n` low → outputs immediately take their reset values.
